// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage placed directly before the opcode decoder. It owns
// the program counter, fetches one 16-bit word at a time from instruction
// memory over a req/ack handshake, and hands each word to the decoder over a
// valid/ready handshake. A branch redirect replaces the PC and squashes any
// fetch that is still in flight.
//
// Optional feature (macro FETCH_STALL_CNT_EN):
//   When defined, adds output stall_cnt, a saturating count of cycles spent
//   waiting on memory (REQ/DRAIN without ack) or on the decoder (HOLD without
//   ready). Only rst_n clears it.
//
// Parameters:
//   PC_W      program counter / word address width
//   RESET_PC  PC value loaded on reset
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem_req       registered fetch request to instruction memory
//   imem_addr      word address of the current request
//   imem_ack       single-cycle ack; imem_rdata valid in the same cycle
//   imem_rdata     instruction word from memory
//   redirect_valid branch redirect pulse
//   redirect_pc    redirect target
//   instr_valid    instruction valid to decoder
//   instr_ready    decoder accepts instruction
//   instr_opcode   fetched instruction word
//   instr_pc       address the instruction was fetched from
//   stall_cnt      stall cycle counter (FETCH_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [15:0]     instr_opcode,
   output logic [PC_W-1:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t            state_q,      state_d;
   logic [PC_W-1:0]   pc_q,         pc_d;
   logic [PC_W-1:0]   drain_addr_q, drain_addr_d;
   logic              req_q,        req_d;
   logic              valid_q,      valid_d;
   logic [15:0]       opcode_q,     opcode_d;
   logic [PC_W-1:0]   ipc_q,        ipc_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         req_q        <= 1'b0;
         valid_q      <= 1'b0;
         opcode_q     <= 16'h0000;
         ipc_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         req_q        <= req_d;
         valid_q      <= valid_d;
         opcode_q     <= opcode_d;
         ipc_q        <= ipc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      req_d        = req_q;
      valid_d      = valid_q;
      opcode_d     = opcode_q;
      ipc_d        = ipc_q;

      unique case (state_q)
         ST_IDLE: begin
            req_d   = 1'b1;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  // Returned word belongs to the old path: drop it.
                  req_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  // Memory still owes us a word; keep asking at the old
                  // address until it arrives, then throw it away.
                  drain_addr_d = pc_q;
                  state_d      = ST_DRAIN;
               end
            end else if (imem_ack) begin
               opcode_d = imem_rdata;
               ipc_d    = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + PC_ONE;
               req_d    = 1'b0;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_d = ST_IDLE;
            end else if (instr_ready) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // Redirect overrides whatever the state logic chose for pc/valid.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
   assign instr_valid  = valid_q;
   assign instr_opcode = opcode_q;
   assign instr_pc     = ipc_q;

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_q;
   logic        stall_inc;

   assign stall_inc = (((state_q == ST_REQ) || (state_q == ST_DRAIN)) && !imem_ack) ||
                      ((state_q == ST_HOLD) && !instr_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 16'h0000;
      end else if (stall_inc && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage sitting directly upstream of the main opcode decoder. Holds the program counter and issues word requests to instruction memory over a req/ack handshake. Registers each returned 16-bit instruction and presents it to the decoder with a valid/ready handshake. Accepts branch redirects from the branch unit and squashes in-flight fetches.

Parameters:
PC_W, 16, program counter / instruction address width (word addressed)
RESET_PC, 0, PC value loaded on reset (PC_W bits)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory (registered)
imem_addr  out  PC_W  word address of current request
imem_ack  in  1  single-cycle pulse, imem_rdata valid in same cycle
imem_rdata  in  16  instruction word from memory
redirect_valid  in  1  branch/redirect pulse
redirect_pc  in  PC_W  redirect target, sampled when redirect_valid=1
instr_valid  out  1  instr_opcode/instr_pc valid to decoder
instr_ready  in  1  decoder accepts instruction
instr_opcode  out  16  fetched instruction; decoder uses bits [15:13]
instr_pc  out  PC_W  address the instruction was fetched from

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_opcode=16'h0000, instr_pc=0. Any outstanding memory request is abandoned; memory must tolerate this.
- States: IDLE, REQ, HOLD, DRAIN. imem_addr always equals pc, except in DRAIN, where it holds the squashed address.
- IDLE: imem_req=0. At the next edge: imem_req<=1, go to REQ.
- REQ: imem_req=1, imem_addr stable. On an edge with imem_ack=1:
  - instr_opcode<=imem_rdata, instr_pc<=pc, instr_valid<=1.
  - pc<=pc+1, modulo 2^PC_W, wraps FFFF->0000 for PC_W=16.
  - imem_req<=0, go to HOLD.
- HOLD: instr_valid=1; instr_opcode/instr_pc stable while instr_ready=0; no memory request. On an edge with instr_ready=1: instr_valid<=0, imem_req<=1, go to REQ. Throughput is therefore at most one instruction per 2 cycles.
- Redirect (edge with redirect_valid=1) takes priority over all other events:
  - pc<=redirect_pc and instr_valid<=0.
  - From REQ with imem_ack=0: keep imem_req=1 at the old address and go to DRAIN.
  - From REQ with imem_ack=1: ack data is discarded; imem_req<=0; go to IDLE.
  - From HOLD: go to IDLE; an instr_ready in the same cycle still counts as accepted, and the result is the same.
  - From IDLE: pc updated; go to REQ as normal, with imem_addr=new pc.
  - From DRAIN: pc updated; stay in DRAIN.
- DRAIN: imem_req=1 at the squashed address until imem_ack. On ack, data is discarded, imem_req<=0, go to IDLE. instr_valid stays 0.
- Redirect-to-request latency from HOLD/REQ: the redirect edge, then one IDLE cycle, then imem_req=1 with imem_addr=redirect_pc.
- instr_valid never rises without a completed, unsquashed memory ack.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0].
  - Increments once per cycle spent in REQ/DRAIN with imem_ack=0, or in HOLD with instr_ready=0.
  - Saturates at 16'hFFFF; reset to 0 by rst_n only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack pulsed on the first REQ cycle with rdata=16'h2A00 -> imem_req=1 at edge 1 with addr 0000; instr_valid=1 at edge 2 with opcode 2A00 and instr_pc 0000.
- instr_ready=1 constant, rdata 16'h2000, 16'h6000, 16'hE000 -> three instructions in order, instr_pc 0,1,2, each valid exactly one cycle.
- instr_ready=0 for 5 cycles in HOLD -> opcode/pc unchanged, imem_req=0 throughout; one fetch resumes after ready rises. Stall counter (if enabled) reads 5.
- Redirect to 0x0040 in HOLD -> instr_valid=0 next cycle, one cycle of imem_req=0, then imem_req=1 with addr 0040.
- Redirect to 0x0040 while REQ is outstanding, ack 3 cycles later with 16'hFFFF -> DRAIN; FFFF never appears with instr_valid=1; next request addr 0040.
- Redirect to 0xFFFF, fetch completes -> instr_pc FFFF; next imem_addr 0000.
